elem_out_packer: RTL and testbench

- Downstream consumer of the int8 elementwise-add stage: collects its one-byte-per-cycle `out`/`valid` result stream.
- Packs PACK consecutive int8 results into one wide word, little-endian by arrival order.
- Buffers packed words in a small FIFO and hands them to the output-buffer writer over a valid/ready handshake.
- The upstream arithmetic pipeline has no backpressure, so this block absorbs writer stalls and flags loss instead of stalling.

---
 rtl/elem_out_packer_pkg.sv | 14 +
 rtl/elem_out_packer_if.sv | 31 +++
 rtl/elem_out_packer_sync_word_fifo.sv | 61 ++++++
 rtl/elem_out_packer.sv | 129 ++++++++++++
 tb/tb_elem_out_packer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/elem_out_packer_pkg.sv
// Shared constants and FSM encoding for the int8 result packer.
package elem_out_packer_pkg;

   localparam int INT8_SIZE  = 8;
   localparam int PACK_LANES = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

endpackage

// File: rtl/elem_out_packer_if.sv
// Control, int8 input stream and packed-word output stream of the result packer.
interface elem_out_packer_if #(
   parameter int PACK  = 8,
   parameter int LEN_W = 32
);
   import elem_out_packer_pkg::*;

   logic                      start;
   logic [LEN_W-1:0]          total_len;
   logic                      in_valid;
   logic [INT8_SIZE-1:0]      in_data;
   logic                      out_valid;
   logic                      out_ready;
   logic [PACK*INT8_SIZE-1:0] out_data;
   logic [PACK-1:0]           out_strb;
   logic                      out_last;
   logic                      busy;
   logic                      done;
   logic                      overflow;

   modport master (
      output start, total_len, in_valid, in_data, out_ready,
      input  out_valid, out_data, out_strb, out_last, busy, done, overflow
   );

   modport slave (
      input  start, total_len, in_valid, in_data, out_ready,
      output out_valid, out_data, out_strb, out_last, busy, done, overflow
   );

endinterface

// File: rtl/elem_out_packer_sync_word_fifo.sv
// Generic first-word-fall-through FIFO, one-cycle write-to-read latency.
// A push into a full FIFO is only taken when a pop happens on the same edge.
module sync_word_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_dat_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_dat_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // Gated so an empty FIFO presents zeros rather than stale storage.
   assign pop_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
   end

endmodule

// File: rtl/elem_out_packer.sv
// Packs PACK int8 results into a wide word; word visible one cycle after its last byte.
// Upstream is never stalled: words arriving at a full, non-popping FIFO are dropped and flagged.
module elem_out_packer
   import elem_out_packer_pkg::*;
#(
   parameter int PACK       = PACK_LANES,
   parameter int FIFO_DEPTH = 4,
   parameter int LEN_W      = 32
) (
   input logic              clk_i,
   input logic              rst_ni,
   elem_out_packer_if.slave bus_if
);
   localparam int DW = PACK * INT8_SIZE;
   localparam int FW = DW + PACK + 1;
   localparam int LW = $clog2(PACK);

   state_e           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d, elem_q, elem_d;
   logic [LW-1:0]    lane_q, lane_d;
   logic [DW-1:0]    asm_q, asm_d, merged;
   logic [PACK-1:0]  strb;
   logic             ovf_q, ovf_d;
   logic             last_elem, push, pop, fifo_full, fifo_empty;
   logic [FW-1:0]    fifo_rd;

   assign pop       = bus_if.out_ready && !fifo_empty;
   assign last_elem = (elem_q == len_q - LEN_W'(1));

   // Word as it would look with the current byte dropped into its lane.
   always_comb begin
      merged = asm_q;
      merged[int'(lane_q)*INT8_SIZE +: INT8_SIZE] = bus_if.in_data;
      strb = '0;
      for (int k = 0; k < PACK; k++) strb[k] = (k <= int'(lane_q));
   end

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      elem_d  = elem_q;
      lane_d  = lane_q;
      asm_d   = asm_q;
      push    = 1'b0;
      ovf_d   = ovf_q | (push_req_drop());
      case (state_q)
         ST_IDLE: begin
            if (bus_if.start) begin
               if (bus_if.total_len != '0) begin
                  state_d = ST_COLLECT;
                  len_d   = bus_if.total_len;
                  elem_d  = '0;
                  lane_d  = '0;
                  asm_d   = '0;
                  ovf_d   = 1'b0;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_COLLECT: begin
            if (bus_if.in_valid) begin
               elem_d = elem_q + LEN_W'(1);
               if (lane_q == LW'(PACK - 1) || last_elem) begin
                  push   = 1'b1;
                  asm_d  = '0;
                  lane_d = '0;
                  if (last_elem) state_d = ST_DRAIN;
               end else begin
                  asm_d  = merged;
                  lane_d = lane_q + LW'(1);
               end
            end
         end
         ST_DRAIN: begin
            // Empty also covers a final word that was dropped on overflow.
            if ((pop && fifo_rd[FW-1]) || fifo_empty) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   function automatic logic push_req_drop();
      return (state_q == ST_COLLECT) && bus_if.in_valid
             && (lane_q == LW'(PACK - 1) || last_elem)
             && fifo_full && !pop;
   endfunction

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         elem_q  <= '0;
         lane_q  <= '0;
         asm_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         elem_q  <= elem_d;
         lane_q  <= lane_d;
         asm_q   <= asm_d;
         ovf_q   <= ovf_d;
      end
   end

   sync_word_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .push_i     (push),
      .push_dat_i ({last_elem, strb, merged}),
      .pop_i      (bus_if.out_ready),
      .pop_dat_o  (fifo_rd),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty)
   );

   assign bus_if.out_valid = !fifo_empty;
   assign bus_if.out_data  = fifo_rd[DW-1:0];
   assign bus_if.out_strb  = fifo_rd[DW +: PACK];
   assign bus_if.out_last  = fifo_rd[FW-1];
   assign bus_if.busy      = (state_q != ST_IDLE);
   assign bus_if.done      = (state_q == ST_DONE);
   assign bus_if.overflow  = ovf_q;

endmodule

// File: tb/tb_elem_out_packer.sv
// Bench for elem_out_packer: table of jobs checked cycle by cycle against a queue-based model.
module tb_elem_out_packer;
   import elem_out_packer_pkg::*;

   localparam int PACK  = 8;
   localparam int DEPTH = 4;
   localparam int LEN_W = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   elem_out_packer_if #(.PACK(PACK), .LEN_W(LEN_W)) bus();

   elem_out_packer #(
      .PACK       (PACK),
      .FIFO_DEPTH (DEPTH),
      .LEN_W      (LEN_W)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus_if (bus.slave)
   );

   typedef struct {
      logic [63:0] dat;
      logic [7:0]  strb;
      logic        last;
   } word_t;

   typedef struct {
      int len;
      int rdy_mode;   // 0 always, 1 held low until all input sent, 2 random, 3 rises with final element
      int pct;        // in_valid probability while collecting
      int dmode;      // 0 counting from 1, 1 random, 2 fixed 7F/80/01
      int exp_words;
      int exp_ovf;    // -1 when not predetermined
   } row_t;

   int          checks = 0;
   int          passed = 0;
   word_t       mq[$];
   word_t       got[$];
   logic [7:0]  cur[$];
   int          m_phase = 0;   // 0 idle, 1 collecting, 2 draining, 3 done
   int          m_len   = 0;
   int          m_sent  = 0;
   logic        m_ovf   = 1'b0;
   logic [7:0]  sp [3] = '{8'h7F, 8'h80, 8'h01};
   row_t        rows [11];

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
   endfunction

   task automatic compare_cycle();
      chk("out_valid", bus.out_valid, mq.size() != 0);
      if (mq.size() != 0) begin
         chk("out_data", bus.out_data, mq[0].dat);
         chk("out_strb", bus.out_strb, mq[0].strb);
         chk("out_last", bus.out_last, mq[0].last);
      end
      chk("busy", bus.busy, m_phase != 0);
      chk("done", bus.done, m_phase == 3);
      chk("overflow", bus.overflow, m_ovf);
   endtask

   task automatic record_pop();
      if (bus.out_valid && bus.out_ready)
         got.push_back('{bus.out_data, bus.out_strb, bus.out_last});
   endtask

   // Applies the effect of the coming rising edge to the model.
   task automatic model_step();
      bit    pop, plast, pre_full, pre_empty, do_push;
      word_t w;
      pop       = bus.out_ready && (mq.size() > 0);
      plast     = pop && mq[0].last;
      pre_full  = mq.size() >= DEPTH;
      pre_empty = mq.size() == 0;
      do_push   = 1'b0;
      w         = '{64'h0, 8'h0, 1'b0};
      case (m_phase)
         0: if (bus.start) begin
            m_len = int'(bus.total_len);
            if (m_len != 0) begin
               m_phase = 1;
               m_ovf   = 1'b0;
               m_sent  = 0;
               cur.delete();
            end else begin
               m_phase = 3;
            end
         end
         1: if (bus.in_valid) begin
            cur.push_back(bus.in_data);
            m_sent++;
            if (cur.size() == PACK || m_sent == m_len) begin
               for (int k = 0; k < cur.size(); k++) w.dat[8*k +: 8] = cur[k];
               w.strb = 8'((1 << cur.size()) - 1);
               w.last = (m_sent == m_len);
               if (!pre_full || pop) do_push = 1'b1;
               else m_ovf = 1'b1;
               cur.delete();
               if (m_sent == m_len) m_phase = 2;
            end
         end
         2: if (plast || pre_empty) m_phase = 3;
         default: m_phase = 0;
      endcase
      if (pop) void'(mq.pop_front());
      if (do_push) mq.push_back(w);
   endtask

   task automatic set_ready(row_t r);
      case (r.rdy_mode)
         0: bus.out_ready = 1'b1;
         1: bus.out_ready = (m_sent >= r.len);
         2: bus.out_ready = 1'($urandom_range(1));
         default: bus.out_ready = (m_sent >= r.len - 1);
      endcase
   endtask

   task automatic drive(row_t r);
      bus.start = 1'b0;
      if (r.pct < 100 && $urandom_range(15) == 0) begin
         bus.start     = 1'b1;
         bus.total_len = LEN_W'($urandom_range(50, 1));
      end
      if (m_phase == 1) begin
         bus.in_valid = ($urandom_range(99) < r.pct);
         case (r.dmode)
            0:       bus.in_data = 8'(m_sent + 1);
            1:       bus.in_data = 8'($urandom);
            default: bus.in_data = sp[m_sent % 3];
         endcase
      end else begin
         bus.in_valid = (r.pct < 100) ? 1'($urandom_range(1)) : 1'b0;
         bus.in_data  = 8'($urandom);
      end
      set_ready(r);
   endtask

   // Starts at a falling edge with the model idle; returns at a falling edge, idle again.
   task automatic run_job(row_t r);
      bit fin;
      fin = 1'b0;
      got.delete();
      m_sent        = 0;
      bus.start     = 1'b1;
      bus.total_len = LEN_W'(r.len);
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      set_ready(r);
      record_pop();
      model_step();
      @(negedge clk);
      for (int c = 0; c < 3000; c++) begin
         compare_cycle();
         if (m_phase == 0) begin
            fin = 1'b1;
            break;
         end
         drive(r);
         record_pop();
         model_step();
         @(negedge clk);
      end
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      if (!fin) begin
         checks++;
         $display("FAIL job_timeout: job of len %0d still active after cycle budget", r.len);
      end
      chk("words_popped", got.size(), r.exp_words);
      if (r.exp_ovf >= 0) chk("overflow_final", bus.overflow, r.exp_ovf);
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.total_len = '0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;

      rows[0]  = '{16,  0, 100, 0, 2,  0};
      rows[1]  = '{3,   0, 100, 2, 1,  0};
      rows[2]  = '{0,   0, 100, 0, 0,  0};
      rows[3]  = '{32,  1, 100, 0, 4,  0};
      rows[4]  = '{40,  1, 100, 0, 4,  1};
      rows[5]  = '{40,  3, 100, 0, 5,  0};
      rows[6]  = '{13,  2, 70,  1, 2, -1};
      rows[7]  = '{1,   2, 60,  1, 1, -1};
      rows[8]  = '{0,   2, 50,  1, 0, -1};
      rows[9]  = '{23,  2, 80,  1, 3, -1};
      rows[10] = '{8,   0, 90,  1, 1, -1};

      #2 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_strb", bus.out_strb, 0);
      chk("rst_out_last", bus.out_last, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_overflow", bus.overflow, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         run_job(rows[i]);
         case (i)
            0: begin
               chk("full_w0", got[0].dat, 64'h0807060504030201);
               chk("full_w0_last", got[0].last, 0);
               chk("full_w1", got[1].dat, 64'h100F0E0D0C0B0A09);
               chk("full_w1_strb", got[1].strb, 8'hFF);
               chk("full_w1_last", got[1].last, 1);
            end
            1: begin
               chk("part_w0", got[0].dat, 64'h0000_0000_0001_807F);
               chk("part_strb", got[0].strb, 8'h07);
               chk("part_last", got[0].last, 1);
            end
            3: begin
               chk("bp_w0", got[0].dat, 64'h0807060504030201);
               chk("bp_w3", got[3].dat, 64'h201F1E1D1C1B1A19);
               chk("bp_w3_last", got[3].last, 1);
            end
            5: begin
               chk("pp_w3", got[3].dat, 64'h201F1E1D1C1B1A19);
               chk("pp_w4", got[4].dat, 64'h2827262524232221);
               chk("pp_w4_last", got[4].last, 1);
            end
            default: ;
         endcase
      end

      // Asynchronous reset in the middle of a job with a word waiting.
      bus.start     = 1'b1;
      bus.total_len = LEN_W'(20);
      bus.out_ready = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'(i + 1);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      chk("pre_rst_busy", bus.busy, 1);
      chk("pre_rst_out_valid", bus.out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", bus.busy, 0);
      chk("arst_out_valid", bus.out_valid, 0);
      chk("arst_out_data", bus.out_data, 0);
      chk("arst_out_strb", bus.out_strb, 0);
      chk("arst_done", bus.done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      mq.delete();
      cur.delete();
      m_phase = 0;
      m_sent  = 0;
      m_ovf   = 1'b0;
      run_job('{8, 0, 100, 0, 1, 0});
      chk("post_rst_w0", got[0].dat, 64'h0807060504030201);
      chk("post_rst_strb", got[0].strb, 8'hFF);
      chk("post_rst_last", got[0].last, 1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
